// File: rtl/keypad_emulator.sv
// Keypad contact emulator: on request, "presses" one key of a 4x4 matrix
// keypad with realistic contact bounce, answering the scanner's active-low
// column drive on the active-low row lines.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 2000,
  parameter int BOUNCE_CYCLES = 200,
  parameter int BOUNCE_PERIOD = 20,
  parameter int GAP_CYCLES    = 500
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic       contact,
  output logic       done,
  output logic [7:0] press_count
);

  localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_LEN = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int PH_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TG_W    = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [TG_W-1:0]   r_tog;
  logic              r_contact;
  logic [3:0]        r_key;
  logic              r_done;
  logic [7:0]        r_count;

  state_t            w_target;
  logic              w_adv;
  logic [3:0]        w_pos;
  logic [3:0]        w_row;

  // Number of cycles spent in each timed state.
  function automatic int f_len(state_t s);
    case (s)
      S_BOUNCE_IN, S_BOUNCE_OUT: return BOUNCE_CYCLES;
      S_HOLD:                    return HOLD_CYCLES;
      S_GAP:                     return GAP_CYCLES;
      default:                   return 0;
    endcase
  endfunction

  // Fixed order of the press sequence.
  function automatic state_t f_succ(state_t s);
    case (s)
      S_IDLE:       return S_BOUNCE_IN;
      S_BOUNCE_IN:  return S_HOLD;
      S_HOLD:       return S_BOUNCE_OUT;
      S_BOUNCE_OUT: return S_GAP;
      default:      return S_IDLE;
    endcase
  endfunction

  // Skip over any state configured with zero length.
  function automatic state_t f_enter(state_t s);
    state_t t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t != S_IDLE && f_len(t) == 0) t = f_succ(t);
    end
    return t;
  endfunction

  // Contact level on the first cycle of a state.
  function automatic logic f_entry_contact(state_t s);
    return (s == S_BOUNCE_IN) || (s == S_HOLD);
  endfunction

  // Keycode to matrix position {row[1:0], col[1:0]}.
  function automatic logic [3:0] f_map(logic [3:0] key);
    case (key)
      4'd1:  return 4'b00_00;
      4'd2:  return 4'b00_01;
      4'd3:  return 4'b00_10;
      4'd10: return 4'b00_11;
      4'd4:  return 4'b01_00;
      4'd5:  return 4'b01_01;
      4'd6:  return 4'b01_10;
      4'd11: return 4'b01_11;
      4'd7:  return 4'b10_00;
      4'd8:  return 4'b10_01;
      4'd9:  return 4'b10_10;
      4'd12: return 4'b10_11;
      4'd14: return 4'b11_00;
      4'd0:  return 4'b11_01;
      4'd15: return 4'b11_10;
      default: return 4'b11_11;  // 13 = D
    endcase
  endfunction

  // Decide whether the current state ends this cycle and where it goes.
  always_comb begin
    w_target = f_enter(f_succ(r_state));
    if (r_state == S_IDLE) w_adv = cmd_valid;
    else                   w_adv = (r_phase == PH_W'(f_len(r_state) - 1));
  end

  // Sequencer: state, phase counter, bounce toggling, key latch and press counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_tog     <= '0;
      r_contact <= 1'b0;
      r_key     <= 4'd0;
      r_done    <= 1'b0;
      r_count   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (w_adv) begin
        r_state   <= w_target;
        r_phase   <= '0;
        r_tog     <= '0;
        r_contact <= f_entry_contact(w_target);
        if (r_state == S_IDLE) r_key <= cmd_key;
        if (w_target == S_IDLE) begin
          r_done  <= 1'b1;
          r_count <= r_count + 8'd1;
        end
      end else if (r_state != S_IDLE) begin
        r_phase <= r_phase + 1'b1;
        if (r_state == S_BOUNCE_IN || r_state == S_BOUNCE_OUT) begin
          if (r_tog == TG_W'(BOUNCE_PERIOD - 1)) begin
            r_tog     <= '0;
            r_contact <= ~r_contact;
          end else begin
            r_tog <= r_tog + 1'b1;
          end
        end
      end
    end
  end

  // Row sense: pull the latched key's row low only while its column is driven.
  always_comb begin
    w_pos = f_map(r_key);
    w_row = 4'b1111;
    if (r_contact && !col[w_pos[1:0]]) w_row[w_pos[3:2]] = 1'b0;
  end

  assign row         = w_row;
  assign cmd_ready   = (r_state == S_IDLE);
  assign contact     = r_contact;
  assign done        = r_done;
  assign press_count = r_count;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no bounce / with bounce),
// per-cycle model of contact and row, press_count scoreboard on done.
module tb_keypad_emulator;

  localparam int A_H = 10, A_B = 0, A_P = 1, A_G = 3;
  localparam int A_T = 2 * A_B + A_H + A_G;
  localparam int B_H = 10, B_B = 8, B_P = 2, B_G = 3;
  localparam int B_T = 2 * B_B + B_H + B_G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn_a, valid_a, ready_a, contact_a, done_a;
  logic [3:0] col_a, row_a, key_a;
  logic [7:0] cnt_a;
  logic       resetn_b, valid_b, ready_b, contact_b, done_b;
  logic [3:0] col_b, row_b, key_b;
  logic [7:0] cnt_b;

  keypad_emulator #(.HOLD_CYCLES(A_H), .BOUNCE_CYCLES(A_B), .BOUNCE_PERIOD(A_P), .GAP_CYCLES(A_G)) u_a (
    .clock(clk), .resetn(resetn_a), .col(col_a), .row(row_a), .cmd_valid(valid_a), .cmd_key(key_a),
    .cmd_ready(ready_a), .contact(contact_a), .done(done_a), .press_count(cnt_a));

  keypad_emulator #(.HOLD_CYCLES(B_H), .BOUNCE_CYCLES(B_B), .BOUNCE_PERIOD(B_P), .GAP_CYCLES(B_G)) u_b (
    .clock(clk), .resetn(resetn_b), .col(col_b), .row(row_b), .cmd_valid(valid_b), .cmd_key(key_b),
    .cmd_ready(ready_b), .contact(contact_b), .done(done_b), .press_count(cnt_b));

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_b[$];
  int exp_a = 0;
  int exp_b = 0;

  // Keypad layout indexed by keycode: r0=1,2,3,A r1=4,5,6,B r2=7,8,9,C r3=*,0,#,D
  int krow[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int kcol[16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

  // Expected contact k cycles after acceptance.
  function automatic logic m_contact(int b, int p, int h, int k);
    if (k < b)             return ((k / p) % 2) == 0;
    else if (k < b + h)    return 1'b1;
    else if (k < 2 * b + h) return ((k - b - h) / p) % 2 == 1;
    else                   return 1'b0;
  endfunction

  function automatic logic [3:0] m_row(int key, logic [3:0] c, logic ct);
    logic [3:0] r;
    r = 4'b1111;
    if (ct && c[kcol[key]] == 1'b0) r[krow[key]] = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid_a = 0; valid_b = 0; key_a = 4'd7; key_b = 4'd7; col_a = 4'b0000; col_b = 4'b0000;
    resetn_a = 1; resetn_b = 1;
    #1 resetn_a = 0; resetn_b = 0;
    #2;
    checks++; if (contact_a !== 1'b0) begin errors++; $display("FAIL reset_contact_a got %b want 0", contact_a); end
    checks++; if (row_a !== 4'b1111) begin errors++; $display("FAIL reset_row_a got %b want 1111", row_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b want 1", ready_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_count_a got %0d want 0", cnt_a); end
    checks++; if (contact_b !== 1'b0) begin errors++; $display("FAIL reset_contact_b got %b want 0", contact_b); end
    checks++; if (row_b !== 4'b1111) begin errors++; $display("FAIL reset_row_b got %b want 1111", row_b); end
    checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL reset_count_b got %0d want 0", cnt_b); end
    valid_a = 1; valid_b = 1;  // ignored while held in reset
    tick(); tick();
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_hold_ready got %b want 1", ready_a); end
    checks++; if (contact_a !== 1'b0) begin errors++; $display("FAIL reset_hold_contact got %b want 0", contact_a); end
    valid_a = 0; valid_b = 0;
    @(negedge clk);
    resetn_a = 1; resetn_b = 1;
  endtask

  task automatic test_basic();
    int e; bit got; logic ec;
    col_a = 4'b1101; key_a = 4'd5; valid_a = 1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL basic_ready_idle got %b want 1", ready_a); end
    tick();
    valid_a = 0; key_a = 4'd9;  // later key changes must not matter
    exp_a = (exp_a + 1) % 256; q_a.push_back(exp_a);
    got = 0;
    for (int k = 0; k <= A_T; k++) begin
      ec = m_contact(A_B, A_P, A_H, k);
      checks++; if (contact_a !== ec) begin errors++; $display("FAIL basic_contact k=%0d got %b want %b", k, contact_a, ec); end
      checks++; if (row_a !== m_row(5, col_a, ec)) begin errors++; $display("FAIL basic_row k=%0d got %b want %b", k, row_a, m_row(5, col_a, ec)); end
      checks++; if (ready_a !== (k == A_T)) begin errors++; $display("FAIL basic_ready k=%0d got %b", k, ready_a); end
      checks++; if (done_a !== (k == A_T)) begin errors++; $display("FAIL basic_done k=%0d got %b", k, done_a); end
      if (done_a === 1'b1) begin
        got = 1;
        if (q_a.size() == 0) begin checks++; errors++; $display("FAIL basic_sb_empty got done want none"); end
        else begin e = q_a.pop_front(); checks++;
          if (cnt_a !== 8'(e)) begin errors++; $display("FAIL basic_count got %0d want %0d", cnt_a, e); end end
      end
      if (k < A_T) tick();
    end
    if (!got) begin checks++; errors++; $display("FAIL basic_done_timeout got none want pulse"); end
  endtask

  task automatic test_bounce();
    int e; bit got; logic ec;
    col_b = 4'b1101; key_b = 4'd5; valid_b = 1;
    tick();
    valid_b = 0; key_b = 4'd1;
    exp_b = (exp_b + 1) % 256; q_b.push_back(exp_b);
    got = 0;
    for (int k = 0; k <= B_T; k++) begin
      ec = m_contact(B_B, B_P, B_H, k);
      checks++; if (contact_b !== ec) begin errors++; $display("FAIL bounce_contact k=%0d got %b want %b", k, contact_b, ec); end
      checks++; if (row_b !== m_row(5, col_b, ec)) begin errors++; $display("FAIL bounce_row k=%0d got %b want %b", k, row_b, m_row(5, col_b, ec)); end
      checks++; if (done_b !== (k == B_T)) begin errors++; $display("FAIL bounce_done k=%0d got %b", k, done_b); end
      if (done_b === 1'b1) begin
        got = 1;
        if (q_b.size() == 0) begin checks++; errors++; $display("FAIL bounce_sb_empty got done want none"); end
        else begin e = q_b.pop_front(); checks++;
          if (cnt_b !== 8'(e)) begin errors++; $display("FAIL bounce_count got %0d want %0d", cnt_b, e); end end
      end
      if (k < B_T) tick();
    end
    if (!got) begin checks++; errors++; $display("FAIL bounce_done_timeout got none want pulse"); end
  endtask

  task automatic test_col_sweep();
    logic [3:0] sweep [6];
    logic ec;
    int e;
    sweep = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b1111};
    col_a = 4'b1111; key_a = 4'd15; valid_a = 1;
    tick();
    valid_a = 0;
    exp_a = (exp_a + 1) % 256; q_a.push_back(exp_a);
    for (int k = 0; k <= A_T; k++) begin
      col_a = sweep[k % 6];
      #1;
      ec = m_contact(A_B, A_P, A_H, k);
      checks++; if (row_a !== m_row(15, col_a, ec)) begin errors++; $display("FAIL sweep_row k=%0d col=%b got %b want %b", k, col_a, row_a, m_row(15, col_a, ec)); end
      if (done_a === 1'b1 && q_a.size() > 0) begin
        e = q_a.pop_front(); checks++;
        if (cnt_a !== 8'(e)) begin errors++; $display("FAIL sweep_count got %0d want %0d", cnt_a, e); end
      end
      if (k < A_T) tick();
    end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL sweep_done_missing got %0d pending want 0", q_a.size()); q_a.delete(); end
  endtask

  task automatic test_hold_valid();
    int k, acc, lk, e;
    logic pr;
    logic [3:0] pk;
    logic ec;
    k = A_T; acc = 0; lk = 0;
    col_a = 4'b0000; valid_a = 1;
    for (int n = 0; n < 2 * (A_T + 1); n++) begin
      key_a = 4'((n * 7 + 3) % 16);
      pr = ready_a; pk = key_a;
      tick();
      key_a = 4'((n * 5 + 2) % 16);
      if (pr) begin k = 0; acc++; lk = int'(pk); exp_a = (exp_a + 1) % 256; q_a.push_back(exp_a); end
      else k++;
      ec = m_contact(A_B, A_P, A_H, k);
      checks++; if (ready_a !== (k == A_T)) begin errors++; $display("FAIL hv_ready n=%0d got %b want %b", n, ready_a, (k == A_T)); end
      checks++; if (row_a !== m_row(lk, col_a, ec)) begin errors++; $display("FAIL hv_row n=%0d got %b want %b", n, row_a, m_row(lk, col_a, ec)); end
      if (done_a === 1'b1) begin
        if (q_a.size() == 0) begin checks++; errors++; $display("FAIL hv_sb_empty got done want none"); end
        else begin e = q_a.pop_front(); checks++;
          if (cnt_a !== 8'(e)) begin errors++; $display("FAIL hv_count got %0d want %0d", cnt_a, e); end end
      end
    end
    valid_a = 0;
    checks++; if (acc != 2) begin errors++; $display("FAIL hv_accepts got %0d want 2", acc); end
  endtask

  task automatic test_reset_mid();
    int e;
    col_a = 4'b1101; key_a = 4'd5; valid_a = 1;
    tick();
    valid_a = 0;
    exp_a = (exp_a + 1) % 256; q_a.push_back(exp_a);
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (row_a !== 4'b1101) begin errors++; $display("FAIL rm_row_hold got %b want 1101", row_a); end
    #2 resetn_a = 0;
    #1;
    checks++; if (row_a !== 4'b1111) begin errors++; $display("FAIL rm_row_async got %b want 1111", row_a); end
    checks++; if (contact_a !== 1'b0) begin errors++; $display("FAIL rm_contact got %b want 0", contact_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", ready_a); end
    q_a.delete(); exp_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rm_done got %b want 0", done_a); end
      checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rm_count got %0d want 0", cnt_a); end
    end
    @(negedge clk);
    resetn_a = 1; valid_a = 1; key_a = 4'd5;
    tick();
    valid_a = 0;
    exp_a = 1; q_a.push_back(exp_a);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rm_first_accept got ready %b want 0", ready_a); end
    checks++; if (contact_a !== 1'b1) begin errors++; $display("FAIL rm_first_contact got %b want 1", contact_a); end
    for (int k = 1; k <= A_T; k++) begin
      tick();
      checks++; if (done_a !== (k == A_T)) begin errors++; $display("FAIL rm_done_after k=%0d got %b", k, done_a); end
      if (done_a === 1'b1 && q_a.size() > 0) begin
        e = q_a.pop_front(); checks++;
        if (cnt_a !== 8'(e)) begin errors++; $display("FAIL rm_count_after got %0d want %0d", cnt_a, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones, cyc, e;
    logic pr;
    @(negedge clk) resetn_a = 0;
    @(negedge clk) resetn_a = 1;
    q_a.delete(); exp_a = 0;
    dones = 0; cyc = 0;
    col_a = 4'b0000; key_a = 4'($urandom_range(0, 15)); valid_a = 1;
    while (dones < 256 && cyc < 256 * (A_T + 1) + 64) begin
      pr = ready_a;
      tick(); cyc++;
      if (pr) begin exp_a = (exp_a + 1) % 256; q_a.push_back(exp_a); key_a = 4'($urandom_range(0, 15)); end
      if (done_a === 1'b1) begin
        dones++;
        if (q_a.size() == 0) begin checks++; errors++; $display("FAIL b2b_sb_empty got done want none"); end
        else begin e = q_a.pop_front(); checks++;
          if (cnt_a !== 8'(e)) begin errors++; $display("FAIL b2b_count n=%0d got %0d want %0d", dones, cnt_a, e); end end
      end
    end
    valid_a = 0;
    checks++; if (dones != 256) begin errors++; $display("FAIL b2b_done_total got %0d want 256", dones); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", cnt_a); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_col_sweep();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
